// File: rtl/control_pkg.sv
// Shared encodings for the pipelined main-control unit: opcodes, write-back and ALU-op codes,
// and the bit layout of the control bundle carried from decode into ID/EX.
package control_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_R      = 2'b10;
  localparam logic [1:0] ALU_OP_IMM    = 2'b11;

  localparam int unsigned CTRL_ALU_SRC   = 0;
  localparam int unsigned CTRL_BRANCH    = 1;
  localparam int unsigned CTRL_JUMP      = 2;
  localparam int unsigned CTRL_MEM_READ  = 3;
  localparam int unsigned CTRL_MEM_WRITE = 4;
  localparam int unsigned CTRL_REG_WRITE = 5;
  localparam int unsigned CTRL_WB_SEL    = 6;  // 2 bits
  localparam int unsigned CTRL_ALU_OP    = 8;  // 2 bits
  localparam int unsigned CTRL_W         = 10;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: control bundle, source-register usage and illegal-opcode flag.
module control_decode
  import control_pkg::*;
#(
  parameter int unsigned EXT_OPS = 1
) (
  input  logic              valid,
  input  logic [6:0]        opcode,
  output logic [CTRL_W-1:0] ctrl,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              illegal
);

  logic known;

  always_comb begin
    ctrl    = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    known   = 1'b1;
    case (opcode)
      OPC_R: begin
        ctrl[CTRL_REG_WRITE]     = 1'b1;
        ctrl[CTRL_ALU_OP +: 2]   = ALU_OP_R;
        use_rs1                  = 1'b1;
        use_rs2                  = 1'b1;
      end
      OPC_LOAD: begin
        ctrl[CTRL_ALU_SRC]       = 1'b1;
        ctrl[CTRL_MEM_READ]      = 1'b1;
        ctrl[CTRL_REG_WRITE]     = 1'b1;
        ctrl[CTRL_WB_SEL +: 2]   = WB_MEM;
        ctrl[CTRL_ALU_OP +: 2]   = ALU_OP_ADD;
        use_rs1                  = 1'b1;
      end
      OPC_STORE: begin
        ctrl[CTRL_ALU_SRC]       = 1'b1;
        ctrl[CTRL_MEM_WRITE]     = 1'b1;
        ctrl[CTRL_ALU_OP +: 2]   = ALU_OP_ADD;
        use_rs1                  = 1'b1;
        use_rs2                  = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl[CTRL_BRANCH]        = 1'b1;
        ctrl[CTRL_ALU_OP +: 2]   = ALU_OP_BRANCH;
        use_rs1                  = 1'b1;
        use_rs2                  = 1'b1;
      end
      OPC_OP_IMM: begin
        if (EXT_OPS != 0) begin
          ctrl[CTRL_ALU_SRC]     = 1'b1;
          ctrl[CTRL_REG_WRITE]   = 1'b1;
          ctrl[CTRL_ALU_OP +: 2] = ALU_OP_IMM;
          use_rs1                = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      OPC_JAL, OPC_JALR: begin
        if (EXT_OPS != 0) begin
          ctrl[CTRL_JUMP]        = 1'b1;
          ctrl[CTRL_REG_WRITE]   = 1'b1;
          ctrl[CTRL_WB_SEL +: 2] = WB_PC4;
          if (opcode == OPC_JALR) begin
            ctrl[CTRL_ALU_SRC]   = 1'b1;
            use_rs1              = 1'b1;
          end
        end else begin
          known = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        if (EXT_OPS != 0) begin
          ctrl[CTRL_ALU_SRC]     = 1'b1;
          ctrl[CTRL_REG_WRITE]   = 1'b1;
          ctrl[CTRL_ALU_OP +: 2] = ALU_OP_ADD;
        end else begin
          known = 1'b0;
        end
      end
      default: known = 1'b0;
    endcase
  end

  assign illegal = valid & ~known;

endmodule

// File: rtl/control_pipeline.sv
// Pipelined main control: decodes in ID, carries the control bundle through ID/EX, EX/MEM and
// MEM/WB, and inserts bubbles for load-use hazards, flushes and invalid/illegal instructions.
module control_pipeline
  import control_pkg::*;
#(
  parameter int unsigned EXT_OPS    = 1,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [6:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  stall_ext,
  input  logic                  flush_id_ex,
  output logic                  hazard_stall,
  output logic                  id_illegal,
  output logic                  ex_valid,
  output logic                  ex_alu_src,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_reg_write,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [1:0]            ex_wb_sel,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_valid,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_reg_write,
  output logic [1:0]            mem_wb_sel,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [1:0]            wb_wb_sel,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  logic [CTRL_W-1:0]     id_ctrl;
  logic                  id_use_rs1, id_use_rs2;
  logic                  id_bubble;

  logic [CTRL_W-1:0]     ex_ctrl_q;
  logic                  ex_valid_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;

  logic                  mem_valid_q, mem_mem_read_q, mem_mem_write_q, mem_reg_write_q;
  logic [1:0]            mem_wb_sel_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;

  logic                  wb_valid_q, wb_reg_write_q;
  logic [1:0]            wb_wb_sel_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;

  control_decode #(
    .EXT_OPS (EXT_OPS)
  ) u_decode (
    .valid   (id_valid),
    .opcode  (id_opcode),
    .ctrl    (id_ctrl),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .illegal (id_illegal)
  );

  // Only a load in EX can produce a result too late for forwarding into the next instruction.
  assign hazard_stall = id_valid & ex_valid_q & ex_ctrl_q[CTRL_MEM_READ] & (ex_rd_q != '0) &
                        ((id_use_rs1 & (ex_rd_q == id_rs1)) | (id_use_rs2 & (ex_rd_q == id_rs2)));

  assign id_bubble = flush_id_ex | hazard_stall | ~id_valid | id_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q       <= '0;
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      mem_valid_q     <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_wb_sel_q    <= '0;
      mem_rd_q        <= '0;
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_wb_sel_q     <= '0;
      wb_rd_q         <= '0;
    end else if (!stall_ext) begin
      if (id_bubble) begin
        ex_ctrl_q  <= '0;
        ex_valid_q <= 1'b0;
        ex_rd_q    <= '0;
      end else begin
        ex_ctrl_q  <= id_ctrl;
        ex_valid_q <= 1'b1;
        ex_rd_q    <= id_rd;
      end
      mem_valid_q     <= ex_valid_q;
      mem_mem_read_q  <= ex_ctrl_q[CTRL_MEM_READ];
      mem_mem_write_q <= ex_ctrl_q[CTRL_MEM_WRITE];
      mem_reg_write_q <= ex_ctrl_q[CTRL_REG_WRITE];
      mem_wb_sel_q    <= ex_ctrl_q[CTRL_WB_SEL +: 2];
      mem_rd_q        <= ex_rd_q;
      wb_valid_q      <= mem_valid_q;
      wb_reg_write_q  <= mem_reg_write_q;
      wb_wb_sel_q     <= mem_wb_sel_q;
      wb_rd_q         <= mem_rd_q;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_alu_src    = ex_ctrl_q[CTRL_ALU_SRC];
  assign ex_branch     = ex_ctrl_q[CTRL_BRANCH];
  assign ex_jump       = ex_ctrl_q[CTRL_JUMP];
  assign ex_mem_read   = ex_ctrl_q[CTRL_MEM_READ];
  assign ex_mem_write  = ex_ctrl_q[CTRL_MEM_WRITE];
  assign ex_reg_write  = ex_ctrl_q[CTRL_REG_WRITE];
  assign ex_alu_op     = ALU_OP_W'(ex_ctrl_q[CTRL_ALU_OP +: 2]);
  assign ex_wb_sel     = ex_ctrl_q[CTRL_WB_SEL +: 2];
  assign ex_rd         = ex_rd_q;
  assign mem_valid     = mem_valid_q;
  assign mem_mem_read  = mem_mem_read_q;
  assign mem_mem_write = mem_mem_write_q;
  assign mem_reg_write = mem_reg_write_q;
  assign mem_wb_sel    = mem_wb_sel_q;
  assign mem_rd        = mem_rd_q;
  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_wb_sel     = wb_wb_sel_q;
  assign wb_rd         = wb_rd_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: one extended-mode instance checked throughout, plus a
// base-mode instance on the same inputs for the opcode-mode scenario.
module tb_control_pipeline;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] BR_OP  = 7'b1100011;
  localparam logic [6:0] IMM_OP = 7'b0010011;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] LUI_OP = 7'b0110111;

  logic clk = 1'b0;
  logic rst, id_valid, stall_ext, flush_id_ex;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic hazard_stall, id_illegal, ex_valid, ex_alu_src, ex_branch, ex_jump, ex_mem_read;
  logic ex_mem_write, ex_reg_write, mem_valid, mem_mem_read, mem_mem_write, mem_reg_write;
  logic wb_valid, wb_reg_write;
  logic [1:0] ex_alu_op, ex_wb_sel, mem_wb_sel, wb_wb_sel;
  logic [4:0] ex_rd, mem_rd, wb_rd;

  logic hazard_stall_n, id_illegal_n, ex_valid_n, ex_alu_src_n, ex_branch_n, ex_jump_n;
  logic ex_mem_read_n, ex_mem_write_n, ex_reg_write_n, mem_valid_n, mem_mem_read_n;
  logic mem_mem_write_n, mem_reg_write_n, wb_valid_n, wb_reg_write_n;
  logic [1:0] ex_alu_op_n, ex_wb_sel_n, mem_wb_sel_n, wb_wb_sel_n;
  logic [4:0] ex_rd_n, mem_rd_n, wb_rd_n;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_pipeline #(.EXT_OPS(1), .REG_ADDR_W(5), .ALU_OP_W(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .stall_ext(stall_ext), .flush_id_ex(flush_id_ex),
    .hazard_stall(hazard_stall), .id_illegal(id_illegal), .ex_valid(ex_valid),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_alu_op(ex_alu_op), .ex_wb_sel(ex_wb_sel), .ex_rd(ex_rd), .mem_valid(mem_valid),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wb_sel(wb_wb_sel), .wb_rd(wb_rd)
  );

  control_pipeline #(.EXT_OPS(0), .REG_ADDR_W(5), .ALU_OP_W(2)) dut_base (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .stall_ext(stall_ext), .flush_id_ex(flush_id_ex),
    .hazard_stall(hazard_stall_n), .id_illegal(id_illegal_n), .ex_valid(ex_valid_n),
    .ex_alu_src(ex_alu_src_n), .ex_branch(ex_branch_n), .ex_jump(ex_jump_n),
    .ex_mem_read(ex_mem_read_n), .ex_mem_write(ex_mem_write_n),
    .ex_reg_write(ex_reg_write_n), .ex_alu_op(ex_alu_op_n), .ex_wb_sel(ex_wb_sel_n),
    .ex_rd(ex_rd_n), .mem_valid(mem_valid_n), .mem_mem_read(mem_mem_read_n),
    .mem_mem_write(mem_mem_write_n), .mem_reg_write(mem_reg_write_n),
    .mem_wb_sel(mem_wb_sel_n), .mem_rd(mem_rd_n), .wb_valid(wb_valid_n),
    .wb_reg_write(wb_reg_write_n), .wb_wb_sel(wb_wb_sel_n), .wb_rd(wb_rd_n)
  );

  // Inputs change 1 time unit after the rising edge; checks happen at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] d);
    id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = d;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_ext = 1'b0; flush_id_ex = 1'b0;
    drive(1'b1, R_OP, 5'd1, 5'd2, 5'd3);
    step(); step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 2'b00) begin
      failures++; $display("FAIL reset_ex got v=%b rw=%b op=%b want 0 0 00", ex_valid, ex_reg_write, ex_alu_op); end
    checks++; if (mem_valid !== 1'b0 || wb_valid !== 1'b0 || mem_rd !== 5'd0 || wb_rd !== 5'd0) begin
      failures++; $display("FAIL reset_mem_wb got mv=%b wv=%b mrd=%0d wrd=%0d want all 0", mem_valid, wb_valid, mem_rd, wb_rd); end
    checks++; if (hazard_stall !== 1'b0 || id_illegal !== 1'b0) begin
      failures++; $display("FAIL reset_comb got hz=%b ill=%b want 0 0", hazard_stall, id_illegal); end
    rst = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_alu_op !== 2'b10 || ex_rd !== 5'd3) begin
      failures++; $display("FAIL release_ex got v=%b rw=%b op=%b rd=%0d want 1 1 10 3", ex_valid, ex_reg_write, ex_alu_op, ex_rd); end
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    step();
    checks++; if (mem_valid !== 1'b1 || mem_reg_write !== 1'b1 || mem_rd !== 5'd3 || ex_valid !== 1'b0) begin
      failures++; $display("FAIL release_mem got mv=%b mrw=%b mrd=%0d exv=%b want 1 1 3 0", mem_valid, mem_reg_write, mem_rd, ex_valid); end
    step();
    checks++; if (wb_valid !== 1'b1 || wb_reg_write !== 1'b1 || wb_rd !== 5'd3 || wb_wb_sel !== 2'b00) begin
      failures++; $display("FAIL release_wb got wv=%b wrw=%b wrd=%0d sel=%b want 1 1 3 00", wb_valid, wb_reg_write, wb_rd, wb_wb_sel); end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5);
    step();
    drive(1'b1, R_OP, 5'd5, 5'd2, 5'd6);
    checks++; if (hazard_stall !== 1'b1) begin
      failures++; $display("FAIL lu_hazard got %b want 1", hazard_stall); end
    step();
    checks++; if (ex_valid !== 1'b0 || mem_mem_read !== 1'b1 || mem_rd !== 5'd5 || hazard_stall !== 1'b0) begin
      failures++; $display("FAIL lu_bubble got exv=%b mmr=%b mrd=%0d hz=%b want 0 1 5 0", ex_valid, mem_mem_read, mem_rd, hazard_stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0 || ex_rd !== 5'd6) begin
      failures++; $display("FAIL lu_issue got v=%b rw=%b mr=%b rd=%0d want 1 1 0 6", ex_valid, ex_reg_write, ex_mem_read, ex_rd); end
    drain();
    // rs2-side dependency through a store
    drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd9);
    step();
    drive(1'b1, ST_OP, 5'd1, 5'd9, 5'd0);
    checks++; if (hazard_stall !== 1'b1) begin
      failures++; $display("FAIL lu_rs2_hazard got %b want 1", hazard_stall); end
    drain();
    // load to x0 never stalls
    drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd0);
    step();
    drive(1'b1, R_OP, 5'd0, 5'd0, 5'd6);
    checks++; if (hazard_stall !== 1'b0) begin
      failures++; $display("FAIL lu_x0_hazard got %b want 0", hazard_stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_alu_op !== 2'b10) begin
      failures++; $display("FAIL lu_x0_issue got v=%b rd=%0d op=%b want 1 6 10", ex_valid, ex_rd, ex_alu_op); end
    drain();
  endtask

  task automatic test_no_false_hazard();
    drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd5);
    step();
    drive(1'b1, LUI_OP, 5'd5, 5'd5, 5'd7);
    checks++; if (hazard_stall !== 1'b0) begin
      failures++; $display("FAIL lui_hazard got %b want 0", hazard_stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_alu_src !== 1'b1 || ex_reg_write !== 1'b1 || ex_alu_op !== 2'b00) begin
      failures++; $display("FAIL lui_issue got v=%b rd=%0d as=%b rw=%b op=%b want 1 7 1 1 00", ex_valid, ex_rd, ex_alu_src, ex_reg_write, ex_alu_op); end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd8);
    step();
    drive(1'b1, ST_OP, 5'd2, 5'd3, 5'd0);
    flush_id_ex = 1'b1;
    step();
    flush_id_ex = 1'b0;
    checks++; if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0) begin
      failures++; $display("FAIL flush_ex got v=%b mw=%b want 0 0", ex_valid, ex_mem_write); end
    checks++; if (mem_valid !== 1'b1 || mem_mem_read !== 1'b1 || mem_rd !== 5'd8 || mem_wb_sel !== 2'b01) begin
      failures++; $display("FAIL flush_mem got v=%b mr=%b rd=%0d sel=%b want 1 1 8 01", mem_valid, mem_mem_read, mem_rd, mem_wb_sel); end
    drain();
  endtask

  task automatic test_stall_ext();
    drive(1'b1, R_OP, 5'd1, 5'd2, 5'd10);
    step();
    drive(1'b1, LD_OP, 5'd1, 5'd0, 5'd4);
    step();
    drive(1'b1, R_OP, 5'd4, 5'd3, 5'd11);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd4 || mem_rd !== 5'd10 || mem_reg_write !== 1'b1 || wb_valid !== 1'b0 || hazard_stall !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d got emr=%b erd=%0d mrd=%0d mrw=%b wv=%b hz=%b want 1 4 10 1 0 1", i, ex_mem_read, ex_rd, mem_rd, mem_reg_write, wb_valid, hazard_stall); end
    end
    stall_ext = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b0 || mem_mem_read !== 1'b1 || mem_rd !== 5'd4 || wb_rd !== 5'd10 || wb_valid !== 1'b1) begin
      failures++; $display("FAIL stall_release got exv=%b mmr=%b mrd=%0d wrd=%0d wv=%b want 0 1 4 10 1", ex_valid, mem_mem_read, mem_rd, wb_rd, wb_valid); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || wb_rd !== 5'd4 || wb_wb_sel !== 2'b01) begin
      failures++; $display("FAIL stall_resume got exv=%b erd=%0d wrd=%0d wsel=%b want 1 11 4 01", ex_valid, ex_rd, wb_rd, wb_wb_sel); end
    drain();
  endtask

  task automatic test_mode();
    drive(1'b1, JAL_OP, 5'd0, 5'd0, 5'd1);
    checks++; if (id_illegal_n !== 1'b1 || id_illegal !== 1'b0) begin
      failures++; $display("FAIL mode_illegal got base=%b ext=%b want 1 0", id_illegal_n, id_illegal); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_jump !== 1'b1 || ex_wb_sel !== 2'b10 || ex_reg_write !== 1'b1 || ex_rd !== 5'd1) begin
      failures++; $display("FAIL mode_ext_jal got v=%b j=%b sel=%b rw=%b rd=%0d want 1 1 10 1 1", ex_valid, ex_jump, ex_wb_sel, ex_reg_write, ex_rd); end
    checks++; if (ex_valid_n !== 1'b0 || ex_jump_n !== 1'b0) begin
      failures++; $display("FAIL mode_base_bubble got v=%b j=%b want 0 0", ex_valid_n, ex_jump_n); end
    drive(1'b1, 7'b1111111, 5'd0, 5'd0, 5'd2);
    checks++; if (id_illegal !== 1'b1) begin
      failures++; $display("FAIL bad_opcode_illegal got %b want 1", id_illegal); end
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      failures++; $display("FAIL bad_opcode_bubble got v=%b rw=%b want 0 0", ex_valid, ex_reg_write); end
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, R_OP, 5'd1, 5'd2, 5'd12);
    step();
    drive(1'b1, BR_OP, 5'd3, 5'd4, 5'd0);
    step();
    checks++; if (ex_branch !== 1'b1 || ex_alu_op !== 2'b01 || ex_reg_write !== 1'b0 || mem_rd !== 5'd12) begin
      failures++; $display("FAIL b2b_branch got br=%b op=%b rw=%b mrd=%0d want 1 01 0 12", ex_branch, ex_alu_op, ex_reg_write, mem_rd); end
    drive(1'b1, IMM_OP, 5'd5, 5'd0, 5'd13);
    step();
    checks++; if (ex_alu_op !== 2'b11 || ex_alu_src !== 1'b1 || ex_rd !== 5'd13 || wb_rd !== 5'd12 || mem_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_opimm got op=%b as=%b rd=%0d wrd=%0d mv=%b want 11 1 13 12 1", ex_alu_op, ex_alu_src, ex_rd, wb_rd, mem_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 5'd0) begin
      failures++; $display("FAIL midreset got ev=%b mv=%b wv=%b wrd=%0d want 0 0 0 0", ex_valid, mem_valid, wb_valid, wb_rd); end
    drain();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_stall_ext();
    test_mode();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
